// File: rtl/dac_serial_tx_pkg.sv
// Shared definitions for the serial DAC transmitter.
//   state_e    : frame FSM states
//   FRAME_BITS : bits per SYNC frame (don't-care + power-down + data)
//   PD_NORMAL  : power-down field value for normal operation
package dac_serial_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int         FRAME_BITS = 16;
   localparam logic [1:0] PD_NORMAL  = 2'b00;

endpackage

// File: rtl/dac_sclk_gen.sv
// Half-period timer and SCLK level generator.
//   Clk, Rest : clock, async active-low reset
//   en        : run the half-period counter (held at zero, sclk high when low)
//   tog_en    : allow sclk to toggle at each half-period boundary
//   tick      : last cycle of a half-period (boundary on the next edge)
//   rise/fall : tick qualified by tog_en; sclk changes level on the next edge
//   sclk      : registered serial clock, idles high
module dac_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic Clk,
   input  logic Rest,
   input  logic en,
   input  logic tog_en,
   output logic tick,
   output logic rise,
   output logic fall,
   output logic sclk
);

   localparam int CW = $clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;

   always_comb begin
      tick   = en && (cnt_q == CW'(CLK_DIV - 1));
      rise   = tick && tog_en && !sclk_q;
      fall   = tick && tog_en && sclk_q;
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!en) begin
         cnt_d  = '0;
         sclk_d = 1'b1;
      end else if (tick) begin
         cnt_d = '0;
         if (tog_en) sclk_d = ~sclk_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         cnt_q  <= '0;
         sclk_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter (SYNC/SCLK/DIN, DAC121S101-class framing).
// Converts a signed sample to offset binary, builds a 16-bit frame and
// shifts it MSB-first. One pending word may be queued while busy.
//   Clk, Rest : clock, async active-low reset
//   dato_in   : signed sample, valid with start
//   start     : one-cycle request strobe
//   sync_n    : frame select, active low
//   sclk      : serial clock, idles high
//   sdin      : serial data, stable around each sclk falling edge
//   busy      : frame or SYNC-high gap in progress
//   done      : one-cycle pulse at frame end
module dac_serial_tx
   import dac_serial_tx_pkg::*;
#(
   parameter int cant_bits = 16,
   parameter int DAC_BITS  = 12,
   parameter int CLK_DIV   = 4
) (
   input  logic                 Clk,
   input  logic                 Rest,
   input  logic [cant_bits-1:0] dato_in,
   input  logic                 start,
   output logic                 sync_n,
   output logic                 sclk,
   output logic                 sdin,
   output logic                 busy,
   output logic                 done
);

   // Offset binary = upper DAC_BITS with the sign bit inverted.
   function automatic logic [FRAME_BITS-1:0] to_frame(input logic [cant_bits-1:0] d);
      logic [cant_bits-1:0] flipped;
      logic [DAC_BITS-1:0]  code;
      flipped = d ^ {1'b1, {(cant_bits-1){1'b0}}};
      code    = DAC_BITS'(flipped >> (cant_bits - DAC_BITS));
      return (FRAME_BITS'(PD_NORMAL) << DAC_BITS) | FRAME_BITS'(code);
   endfunction

   state_e                state_q, state_d;
   logic [FRAME_BITS-2:0] sh_q, sh_d;        // bits still to send after sdin
   logic [4:0]            bit_cnt_q, bit_cnt_d;
   logic                  pend_q, pend_d;
   logic [cant_bits-1:0]  pend_word_q, pend_word_d;
   logic                  sync_n_q, sync_n_d;
   logic                  sdin_q, sdin_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  tick, rise, fall;
   logic                  launch;
   logic [cant_bits-1:0]  launch_word;
   logic [FRAME_BITS-1:0] ld_frame;

   dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .Clk    (Clk),
      .Rest   (Rest),
      .en     (state_q != ST_IDLE),
      .tog_en (state_q == ST_SHIFT),
      .tick   (tick),
      .rise   (rise),
      .fall   (fall),
      .sclk   (sclk)
   );

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      bit_cnt_d   = bit_cnt_q;
      pend_d      = pend_q;
      pend_word_d = pend_word_q;
      sync_n_d    = sync_n_q;
      sdin_d      = sdin_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      launch      = 1'b0;
      launch_word = dato_in;

      case (state_q)
         ST_IDLE: begin
            if (start) launch = 1'b1;
         end
         ST_SHIFT: begin
            if (start) begin
               pend_d      = 1'b1;
               pend_word_d = dato_in;
            end
            if (fall) bit_cnt_d = bit_cnt_q + 5'd1;
            if (rise) begin
               // Rise after the last falling edge closes the frame.
               if (bit_cnt_q == 5'(FRAME_BITS)) begin
                  state_d  = ST_GAP;
                  sync_n_d = 1'b1;
                  sdin_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  sdin_d = sh_q[FRAME_BITS-2];
                  sh_d   = {sh_q[FRAME_BITS-3:0], 1'b0};
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               // A start in the exit cycle is newer than any pending word.
               if (start) begin
                  launch = 1'b1;
               end else if (pend_q) begin
                  launch      = 1'b1;
                  launch_word = pend_word_q;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end else if (start) begin
               pend_d      = 1'b1;
               pend_word_d = dato_in;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ld_frame = to_frame(launch_word);
      if (launch) begin
         state_d   = ST_SHIFT;
         sh_d      = ld_frame[FRAME_BITS-2:0];
         sdin_d    = ld_frame[FRAME_BITS-1];
         sync_n_d  = 1'b0;
         busy_d    = 1'b1;
         bit_cnt_d = '0;
         pend_d    = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         state_q     <= ST_IDLE;
         sh_q        <= '0;
         bit_cnt_q   <= '0;
         pend_q      <= 1'b0;
         pend_word_q <= '0;
         sync_n_q    <= 1'b1;
         sdin_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         bit_cnt_q   <= bit_cnt_d;
         pend_q      <= pend_d;
         pend_word_q <= pend_word_d;
         sync_n_q    <= sync_n_d;
         sdin_q      <= sdin_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign sync_n = sync_n_q;
   assign sdin   = sdin_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
